opendap_swd_host: RTL and testbench

SWD initiator (probe-side host) for the OpenDAP project. It generates SWCLK from a single system clock and serialises line-reset, raw-bit and DP/AP transfer commands onto SWDIO. It returns ACK, read data and a parity status per command. It sits between a host command source (USB/CPU bridge) and the wire facing an SW-DP. It is also the bench driver for the SW-DP.

---
 rtl/opendap_swd_pkg.sv | 43 ++++
 rtl/opendap_swd_clkgen.sv | 44 ++++
 rtl/opendap_swd_host.sv | 219 +++++++++++++++++++++
 tb/tb_opendap_swd_host.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opendap_swd_pkg.sv
// OpenDAP SWD host shared definitions.
// ACK codes, command encodings, header framing and FSM states.
package opendap_swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam logic [1:0] OP_XFER = 2'd0;
  localparam logic [1:0] OP_LRST = 2'd1;
  localparam logic [1:0] OP_RAW  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  localparam logic HDR_START = 1'b1;
  localparam logic HDR_STOP  = 1'b0;
  localparam logic HDR_PARK  = 1'b1;

  localparam logic [5:0] LRST_ONES = 6'd50;
  localparam logic [5:0] LRST_LAST = 6'd51;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_TRN1,
    S_ACK,
    S_RDATA,
    S_TRN2,
    S_WDATA,
    S_RAW,
    S_DONE
  } state_t;

  function automatic logic [7:0] swd_hdr(
    input logic       ap,
    input logic       rnw,
    input logic [1:0] a
  );
    return {HDR_PARK, HDR_STOP,
            ap ^ rnw ^ a[0] ^ a[1],
            a[1], a[0], rnw, ap, HDR_START};
  endfunction

endpackage

// File: rtl/opendap_swd_clkgen.sv
// SWCLK generator: half-period counter with
// fall/rise strobes one cycle ahead of the edge.
module opendap_swd_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             swclk_out,
  output logic             fall_tick,
  output logic             rise_tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  assign wrap      = run && (cnt == div_q);
  assign rise_tick = wrap && !swclk_out;
  assign fall_tick = wrap && swclk_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      cnt       <= '0;
      swclk_out <= 1'b0;
    end else if (start) begin
      div_q     <= clkdiv;
      cnt       <= '0;
      swclk_out <= 1'b0;
    end else if (!run) begin
      cnt       <= '0;
      swclk_out <= 1'b0;
    end else if (wrap) begin
      cnt       <= '0;
      swclk_out <= ~swclk_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/opendap_swd_host.sv
// OpenDAP SWD initiator: serialises line reset, raw
// and DP/AP transfers; returns ACK, rdata, parity.
module opendap_swd_host
  import opendap_swd_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             swclk_out,
  output logic             swdo,
  output logic             swdo_en,
  input  logic             swdi,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_ap_ndp,
  input  logic             cmd_r_nw,
  input  logic [1:0]       cmd_addr,
  input  logic             cmd_no_ack,
  input  logic [31:0]      cmd_wdata,
  input  logic [4:0]       cmd_len,
  output logic             rsp_valid,
  output logic [2:0]       rsp_ack,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_parity_err
);

  state_t      state, state_d;
  logic [5:0]  bitcnt, bitcnt_d, bit_inc;
  logic [32:0] sr, sr_d;
  logic [2:0]  ack_q, ack_d;
  logic        ok_q, ok_d;
  logic        swdo_d, swdo_en_d;
  logic [1:0]  op_q;
  logic        rnw_q, no_ack_q;
  logic [31:0] wdata_q;
  logic [4:0]  len_q;
  logic        accept, run, lr;
  logic        fall_tick, rise_tick;
  logic [5:0]  raw_last;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign run       = !(state inside {S_IDLE, S_DONE});
  assign lr        = (op_q == OP_LRST);
  assign bit_inc   = bitcnt + 6'd1;
  assign raw_last  = lr ? LRST_LAST : {1'b0, len_q};

  opendap_swd_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .run       (run),
    .clkdiv    (clkdiv),
    .swclk_out (swclk_out),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_comb begin
    state_d   = state;
    bitcnt_d  = bitcnt;
    sr_d      = sr;
    ack_d     = ack_q;
    ok_d      = ok_q;
    swdo_d    = swdo;
    swdo_en_d = swdo_en;
    unique case (state)
      S_IDLE: if (accept) begin
        bitcnt_d  = '0;
        ack_d     = '0;
        ok_d      = 1'b0;
        swdo_en_d = 1'b1;
        unique case (cmd_op)
          OP_XFER: begin
            state_d = S_HDR;
            sr_d    = {25'b0, swd_hdr(cmd_ap_ndp,
                                      cmd_r_nw,
                                      cmd_addr)};
            swdo_d  = HDR_START;
          end
          OP_LRST: begin
            state_d = S_RAW;
            sr_d    = '0;
            swdo_d  = 1'b1;
          end
          default: begin
            state_d = S_RAW;
            sr_d    = {1'b0, cmd_wdata};
            swdo_d  = cmd_wdata[0];
          end
        endcase
      end
      S_HDR: if (fall_tick) begin
        if (bitcnt == 6'd7) begin
          state_d   = S_TRN1;
          bitcnt_d  = '0;
          swdo_d    = 1'b0;
          swdo_en_d = 1'b0;
        end else begin
          bitcnt_d = bit_inc;
          sr_d     = sr >> 1;
          swdo_d   = sr[1];
        end
      end
      S_TRN1: if (fall_tick) begin
        state_d  = S_ACK;
        bitcnt_d = '0;
      end
      S_ACK: begin
        if (rise_tick) ack_d[bitcnt[1:0]] = swdi;
        if (fall_tick) begin
          bitcnt_d = bit_inc;
          if (bitcnt == 6'd2) begin
            // TARGETSEL has no ACK; proceed as if OK
            ok_d     = (ack_q == ACK_OK) || no_ack_q;
            bitcnt_d = '0;
            state_d  = (ok_d && rnw_q) ? S_RDATA : S_TRN2;
          end
        end
      end
      S_RDATA: begin
        if (rise_tick) sr_d = {swdi, sr[32:1]};
        if (fall_tick) begin
          bitcnt_d = bit_inc;
          if (bitcnt == 6'd32) begin
            state_d  = S_TRN2;
            bitcnt_d = '0;
          end
        end
      end
      S_TRN2: if (fall_tick) begin
        bitcnt_d = '0;
        if (ok_q && !rnw_q) begin
          state_d   = S_WDATA;
          sr_d      = {^wdata_q, wdata_q};
          swdo_d    = wdata_q[0];
          swdo_en_d = 1'b1;
        end else begin
          state_d = S_DONE;
          swdo_d  = 1'b0;
        end
      end
      S_WDATA: if (fall_tick) begin
        if (bitcnt == 6'd32) begin
          state_d = S_DONE;
          swdo_d  = 1'b0;
        end else begin
          bitcnt_d = bit_inc;
          sr_d     = sr >> 1;
          swdo_d   = sr[1];
        end
      end
      S_RAW: if (fall_tick) begin
        if (bitcnt == raw_last) begin
          state_d = S_DONE;
          swdo_d  = 1'b0;
        end else begin
          bitcnt_d = bit_inc;
          sr_d     = sr >> 1;
          swdo_d   = lr ? (bit_inc < LRST_ONES)
                        : sr[1];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bitcnt         <= '0;
      sr             <= '0;
      ack_q          <= '0;
      ok_q           <= 1'b0;
      swdo           <= 1'b0;
      swdo_en        <= 1'b0;
      op_q           <= OP_XFER;
      rnw_q          <= 1'b0;
      no_ack_q       <= 1'b0;
      wdata_q        <= '0;
      len_q          <= '0;
      rsp_ack        <= '0;
      rsp_rdata      <= '0;
      rsp_parity_err <= 1'b0;
    end else begin
      state   <= state_d;
      bitcnt  <= bitcnt_d;
      sr      <= sr_d;
      ack_q   <= ack_d;
      ok_q    <= ok_d;
      swdo    <= swdo_d;
      swdo_en <= swdo_en_d;
      if (accept) begin
        op_q     <= cmd_op;
        rnw_q    <= cmd_r_nw;
        no_ack_q <= cmd_no_ack;
        wdata_q  <= cmd_wdata;
        len_q    <= cmd_len;
      end
      if (state_d == S_DONE && state != S_DONE) begin
        rsp_ack        <= '0;
        rsp_parity_err <= 1'b0;
        if (op_q == OP_XFER) begin
          rsp_ack <= ack_q;
          if (rnw_q && ok_q) begin
            rsp_rdata      <= sr[31:0];
            rsp_parity_err <= (^sr[31:0]) ^ sr[32];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_opendap_swd_host.sv
// Directed bench for opendap_swd_host with a small
// scripted SW-DP target on the wire.
module tb_opendap_swd_host;

  localparam logic [31:0] DPIDR = 32'h0BC1_2477;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  clkdiv;
  logic        swclk_out, swdo, swdo_en, swdi;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_ap_ndp, cmd_r_nw;
  logic [1:0]  cmd_addr;
  logic        cmd_no_ack;
  logic [31:0] cmd_wdata;
  logic [4:0]  cmd_len;
  logic        rsp_valid;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_parity_err;

  int n_vec = 0;
  int n_bad = 0;

  int          p;
  int          nrise;
  int          rsp_cnt = 0;
  logic [63:0] cap;
  logic [7:0]  exp_hdr;
  logic        tgt_xfer, tgt_silent;
  logic        ap_rdy;
  logic [31:0] ap_data, ctrl;
  logic        en_lo_bad, en_all;
  logic        t_ap, t_rnw, t_par;
  logic [1:0]  t_a;
  logic [2:0]  t_ack;
  logic [31:0] t_rd;

  opendap_swd_host #(.DIV_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clkdiv         (clkdiv),
    .swclk_out      (swclk_out),
    .swdo           (swdo),
    .swdo_en        (swdo_en),
    .swdi           (swdi),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_ap_ndp     (cmd_ap_ndp),
    .cmd_r_nw       (cmd_r_nw),
    .cmd_addr       (cmd_addr),
    .cmd_no_ack     (cmd_no_ack),
    .cmd_wdata      (cmd_wdata),
    .cmd_len        (cmd_len),
    .rsp_valid      (rsp_valid),
    .rsp_ack        (rsp_ack),
    .rsp_rdata      (rsp_rdata),
    .rsp_parity_err (rsp_parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rsp_valid) rsp_cnt++;

  // target: sample host bits on SWCLK rise
  always @(posedge swclk_out) begin
    nrise++;
    if (p < 64) cap[p] = swdo;
    if (p >= 8 && p <= 12 && swdo_en) en_lo_bad = 1'b1;
    if (!swdo_en) en_all = 1'b0;
    if (tgt_xfer && p == 7) begin
      chk("hdr", {56'b0, cap[7:0]}, {56'b0, exp_hdr});
      t_ap  = cap[1];
      t_rnw = cap[2];
      t_a   = cap[4:3];
      if (tgt_silent)         t_ack = 3'b000;
      else if (t_ap && !ap_rdy) t_ack = 3'b010;
      else                    t_ack = 3'b001;
      if (t_ap)           t_rd = ap_data;
      else if (t_a == 0)  t_rd = DPIDR;
      else if (t_a == 1)  t_rd = ctrl |
                            ((ctrl & 32'h5000_0000) << 1);
      else                t_rd = 32'h0;
      // corrupt parity on data 1
      t_par = (^t_rd) ^ (t_rd == 32'h1);
    end
    if (tgt_xfer && !t_rnw && p == 45 &&
        (t_ack == 3'b001 || tgt_silent)) begin
      chk("wpar", {63'b0, swdo}, {63'b0, ^cap[44:13]});
      if (!t_ap && t_a == 2'd1) ctrl = cap[44:13];
    end
  end

  // target: drive swdi for the new period
  always @(negedge swclk_out) begin
    p = p + 1;
    swdi = 1'b0;
    if (tgt_xfer) begin
      if (p >= 9 && p <= 11)
        swdi = t_ack[p-9];
      else if (t_rnw && t_ack == 3'b001 &&
               p >= 12 && p <= 43)
        swdi = t_rd[p-12];
      else if (t_rnw && t_ack == 3'b001 && p == 44)
        swdi = t_par;
    end
  end

  task automatic start_cmd(
    input logic [1:0]  op,
    input logic        ap,
    input logic        rnw,
    input logic [1:0]  a,
    input logic        na,
    input logic [31:0] wd,
    input logic [4:0]  len,
    input logic [7:0]  div
  );
    int n;
    @(negedge clk);
    cmd_op     = op;
    cmd_ap_ndp = ap;
    cmd_r_nw   = rnw;
    cmd_addr   = a;
    cmd_no_ack = na;
    cmd_wdata  = wd;
    cmd_len    = len;
    clkdiv     = div;
    cmd_valid  = 1'b1;
    exp_hdr    = {1'b1, 1'b0, ap ^ rnw ^ a[0] ^ a[1],
                  a[1], a[0], rnw, ap, 1'b1};
    tgt_xfer   = (op == 2'd0);
    p          = 0;
    nrise      = 0;
    cap        = '0;
    en_lo_bad  = 1'b0;
    en_all     = 1'b1;
    swdi       = 1'b0;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_wdata  = $urandom;
    cmd_len    = 5'($urandom);
    cmd_r_nw   = ~rnw;
    cmd_no_ack = ~na;
    clkdiv     = 8'($urandom);
    chk("rdy_drop", {63'b0, cmd_ready}, 64'd0);
  endtask

  task automatic issue(
    input  logic [1:0]  op,
    input  logic        ap,
    input  logic        rnw,
    input  logic [1:0]  a,
    input  logic        na,
    input  logic [31:0] wd,
    input  logic [4:0]  len,
    input  logic [7:0]  div,
    output int          lat
  );
    start_cmd(op, ap, rnw, a, na, wd, len, div);
    lat = 0;
    while (!rsp_valid && lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
    end
    @(posedge clk);
    #1;
    chk("rdy_back", {63'b0, cmd_ready}, 64'd1);
    chk("vld_pulse", {63'b0, rsp_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    int k, n;
    logic [63:0] lr_exp;
    lr_exp     = {14'b0, {50{1'b1}}};
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_ap_ndp = 1'b0;
    cmd_r_nw   = 1'b0;
    cmd_addr   = '0;
    cmd_no_ack = 1'b0;
    cmd_wdata  = '0;
    cmd_len    = '0;
    clkdiv     = '0;
    swdi       = 1'b0;
    p          = 0;
    nrise      = 0;
    cap        = '0;
    tgt_xfer   = 1'b0;
    tgt_silent = 1'b0;
    ap_rdy     = 1'b1;
    ap_data    = '0;
    ctrl       = '0;
    t_ack      = '0;
    t_rnw      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_swclk", {63'b0, swclk_out}, 0);
    chk("rst_swdo", {63'b0, swdo}, 0);
    chk("rst_en", {63'b0, swdo_en}, 0);
    chk("rst_rdy", {63'b0, cmd_ready}, 1);
    chk("rst_vld", {63'b0, rsp_valid}, 0);
    chk("rst_ack", {61'b0, rsp_ack}, 0);
    chk("rst_rdata", {32'b0, rsp_rdata}, 0);
    chk("rst_perr", {63'b0, rsp_parity_err}, 0);
    rst_n = 1'b1;

    issue(2'd1, 0, 0, 2'd0, 0, 32'h0, 5'd0, 8'd0, lat);
    chk("lr_lat", 64'(lat), 104);
    chk("lr_edges", 64'(nrise), 52);
    chk("lr_bits", cap, lr_exp);
    chk("lr_en", {63'b0, en_all}, 1);
    chk("lr_ack", {61'b0, rsp_ack}, 0);
    chk("lr_rdata", {32'b0, rsp_rdata}, 0);

    issue(2'd0, 0, 1, 2'd0, 0, 32'h0, 5'd0, 8'd0, lat);
    chk("idr_lat", 64'(lat), 92);
    chk("idr_edges", 64'(nrise), 46);
    chk("idr_ack", {61'b0, rsp_ack}, 1);
    chk("idr_rdata", {32'b0, rsp_rdata}, {32'b0, DPIDR});
    chk("idr_perr", {63'b0, rsp_parity_err}, 0);
    chk("idr_trn", {63'b0, en_lo_bad}, 0);
    chk("idr_en_end", {63'b0, swdo_en}, 0);

    issue(2'd0, 0, 0, 2'd1, 0, 32'h5000_0000,
          5'd0, 8'd1, lat);
    chk("wr_lat", 64'(lat), 184);
    chk("wr_ack", {61'b0, rsp_ack}, 1);
    chk("wr_perr", {63'b0, rsp_parity_err}, 0);
    chk("wr_en_end", {63'b0, swdo_en}, 1);
    chk("wr_ctrl", {32'b0, ctrl}, 64'h5000_0000);

    issue(2'd0, 0, 1, 2'd1, 0, 32'h0, 5'd0, 8'd0, lat);
    chk("cs_ack", {61'b0, rsp_ack}, 1);
    chk("cs_rdata", {32'b0, rsp_rdata}, 64'hF000_0000);

    ap_rdy = 1'b0;
    issue(2'd0, 1, 1, 2'd0, 0, 32'h0, 5'd0, 8'd2, lat);
    chk("wait_ack", {61'b0, rsp_ack}, 2);
    chk("wait_edges", 64'(nrise), 13);
    chk("wait_lat", 64'(lat), 78);
    chk("wait_trn", {63'b0, en_lo_bad}, 0);
    chk("wait_en_end", {63'b0, swdo_en}, 0);
    chk("wait_perr", {63'b0, rsp_parity_err}, 0);

    ap_rdy  = 1'b1;
    ap_data = 32'h0000_0001;
    issue(2'd0, 1, 1, 2'd3, 0, 32'h0, 5'd0, 8'd0, lat);
    chk("bad_ack", {61'b0, rsp_ack}, 1);
    chk("bad_perr", {63'b0, rsp_parity_err}, 1);
    chk("bad_rdata", {32'b0, rsp_rdata}, 1);

    ap_data = 32'h8000_0003;
    issue(2'd0, 1, 1, 2'd2, 0, 32'h0, 5'd0, 8'd0, lat);
    chk("ap_perr", {63'b0, rsp_parity_err}, 0);
    chk("ap_rdata", {32'b0, rsp_rdata}, 64'h8000_0003);

    issue(2'd2, 0, 0, 2'd0, 0, 32'h0000_E79E,
          5'd15, 8'd3, lat);
    chk("raw_lat", 64'(lat), 128);
    chk("raw_edges", 64'(nrise), 16);
    chk("raw_bits", cap, 64'hE79E);
    chk("raw_en", {63'b0, en_all}, 1);
    chk("raw_ack", {61'b0, rsp_ack}, 0);
    chk("raw_rdata", {32'b0, rsp_rdata}, 64'h8000_0003);

    issue(2'd3, 0, 0, 2'd0, 0, 32'h1, 5'd0, 8'd0, lat);
    chk("op3_lat", 64'(lat), 2);
    chk("op3_bits", cap, 1);

    tgt_silent = 1'b1;
    issue(2'd0, 0, 0, 2'd3, 1, 32'h0100_2927,
          5'd0, 8'd0, lat);
    chk("ts_lat", 64'(lat), 92);
    chk("ts_edges", 64'(nrise), 46);
    chk("ts_ack", {61'b0, rsp_ack}, 0);
    chk("ts_perr", {63'b0, rsp_parity_err}, 0);
    tgt_silent = 1'b0;

    start_cmd(2'd0, 0, 0, 2'd1, 0, 32'h1234_5678,
              5'd0, 8'd0);
    n = 0;
    while (p < 20 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("ar_reach", {63'b0, p >= 20}, 1);
    #1;
    k = rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk("ar_swclk", {63'b0, swclk_out}, 0);
    chk("ar_swdo", {63'b0, swdo}, 0);
    chk("ar_en", {63'b0, swdo_en}, 0);
    chk("ar_rdy", {63'b0, cmd_ready}, 1);
    chk("ar_ack", {61'b0, rsp_ack}, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("ar_no_rsp", 64'(rsp_cnt), 64'(k));
    chk("ar_ctrl", {32'b0, ctrl}, 64'h5000_0000);

    issue(2'd1, 0, 0, 2'd0, 0, 32'h0, 5'd0, 8'd0, lat);
    issue(2'd0, 0, 1, 2'd0, 0, 32'h0, 5'd0, 8'd0, lat);
    chk("ar_idr_ack", {61'b0, rsp_ack}, 1);
    chk("ar_idr_rd", {32'b0, rsp_rdata}, {32'b0, DPIDR});

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
